// File: rtl/frame_reader_if.sv
// Signal bundle between the frame reader, the frame memory read port and the VGA DAC pins.
// The master side is the reader; the slave side is the memory plus display.
interface frame_reader_if;
   logic        calculating;
   logic        rd_en;
   logic [18:0] rd_addr;
   logic [7:0]  rd_data;
   logic        hs;
   logic        vs;
   logic        blank_n;
   logic [7:0]  red;
   logic [7:0]  green;
   logic [7:0]  blue;
   logic        frame_start;

   modport master (
      input  calculating, rd_data,
      output rd_en, rd_addr, hs, vs, blank_n, red, green, blue, frame_start
   );

   modport slave (
      output calculating, rd_data,
      input  rd_en, rd_addr, hs, vs, blank_n, red, green, blue, frame_start
   );
endinterface

// File: rtl/frame_reader.sv
// VGA timing generator that streams the intensity frame buffer to grayscale RGB,
// delaying syncs to line up with the memory read latency and muting partial frames.
module frame_reader #(
   parameter int H_ACTIVE = 640,
   parameter int H_FP     = 16,
   parameter int H_SYNC   = 96,
   parameter int H_BP     = 48,
   parameter int V_ACTIVE = 480,
   parameter int V_FP     = 10,
   parameter int V_SYNC   = 2,
   parameter int V_BP     = 33,
   parameter int RD_LAT   = 2
) (
   input  logic           CLK,
   input  logic           RESET_N,
   frame_reader_if.master bus
);

   localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
   localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
   localparam int HC_W    = $clog2(H_TOTAL);
   localparam int VC_W    = $clog2(V_TOTAL);

   localparam logic [HC_W-1:0] HC_MAX  = HC_W'(H_TOTAL - 1);
   localparam logic [HC_W-1:0] HC_ACT  = HC_W'(H_ACTIVE);
   localparam logic [HC_W-1:0] HS_ON   = HC_W'(H_ACTIVE + H_FP);
   localparam logic [HC_W-1:0] HS_OFF  = HC_W'(H_ACTIVE + H_FP + H_SYNC);
   localparam logic [VC_W-1:0] VC_MAX  = VC_W'(V_TOTAL - 1);
   localparam logic [VC_W-1:0] VC_ACT  = VC_W'(V_ACTIVE);
   localparam logic [VC_W-1:0] VS_ON   = VC_W'(V_ACTIVE + V_FP);
   localparam logic [VC_W-1:0] VS_OFF  = VC_W'(V_ACTIVE + V_FP + V_SYNC);

   logic [HC_W-1:0] hc_q, hc_d;
   logic [VC_W-1:0] vc_q, vc_d;
   logic [18:0]     addr_q, addr_d;
   logic            mute_q, mute_d;
   logic [RD_LAT:0] hs_pipe_q, vs_pipe_q, act_pipe_q, fs_pipe_q;
   logic [7:0]      pix_q, pix_d;

   logic active, hs_i, vs_i, fs_i, frame_end;

   always_comb begin
      active    = (hc_q < HC_ACT) && (vc_q < VC_ACT);
      hs_i      = !((hc_q >= HS_ON) && (hc_q < HS_OFF));
      vs_i      = !((vc_q >= VS_ON) && (vc_q < VS_OFF));
      fs_i      = (hc_q == '0) && (vc_q == '0);
      frame_end = (hc_q == HC_MAX) && (vc_q == VC_MAX);
   end

   always_comb begin
      hc_d   = hc_q + 1'b1;
      vc_d   = vc_q;
      addr_d = addr_q;
      if (hc_q == HC_MAX) begin
         hc_d = '0;
         vc_d = (vc_q == VC_MAX) ? '0 : vc_q + 1'b1;
      end
      // The address counter replaces y*H_ACTIVE+x; it only moves on pixels actually read.
      if (frame_end) begin
         addr_d = '0;
      end else if (active) begin
         addr_d = addr_q + 19'd1;
      end
   end

   // Setting wins over the frame-start clear, so a pass touching the first pixel still mutes.
   always_comb begin
      mute_d = mute_q;
      if (bus.calculating) begin
         mute_d = 1'b1;
      end else if (fs_i) begin
         mute_d = 1'b0;
      end
   end

   // Stage RD_LAT-1 of the active pipe lines up with the returning read data.
   always_comb begin
      pix_d = 8'd0;
      if (act_pipe_q[RD_LAT-1] && !mute_q) begin
         pix_d = bus.rd_data;
      end
   end

   always_ff @(posedge CLK or negedge RESET_N) begin
      if (!RESET_N) begin
         hc_q       <= '0;
         vc_q       <= '0;
         addr_q     <= '0;
         mute_q     <= 1'b1;
         hs_pipe_q  <= '1;
         vs_pipe_q  <= '1;
         act_pipe_q <= '0;
         fs_pipe_q  <= '0;
         pix_q      <= 8'd0;
      end else begin
         hc_q       <= hc_d;
         vc_q       <= vc_d;
         addr_q     <= addr_d;
         mute_q     <= mute_d;
         hs_pipe_q  <= {hs_pipe_q[RD_LAT-1:0], hs_i};
         vs_pipe_q  <= {vs_pipe_q[RD_LAT-1:0], vs_i};
         act_pipe_q <= {act_pipe_q[RD_LAT-1:0], active};
         fs_pipe_q  <= {fs_pipe_q[RD_LAT-1:0], fs_i};
         pix_q      <= pix_d;
      end
   end

   assign bus.rd_en       = active;
   assign bus.rd_addr     = addr_q;
   assign bus.hs          = hs_pipe_q[RD_LAT];
   assign bus.vs          = vs_pipe_q[RD_LAT];
   assign bus.blank_n     = act_pipe_q[RD_LAT];
   assign bus.frame_start = fs_pipe_q[RD_LAT];
   assign bus.red         = pix_q;
   assign bus.green       = pix_q;
   assign bus.blue        = pix_q;

endmodule

// File: tb/tb_frame_reader.sv
// Bench for frame_reader on a shrunken raster: a position-based reference model predicts
// every output each cycle, a monitor compares the DUT against the queued predictions.
module tb_frame_reader;
   localparam int HA = 16, HFP = 2, HSW = 3, HBP = 3;
   localparam int VA = 6,  VFP = 1, VSW = 2, VBP = 2;
   localparam int L  = 2;
   localparam int HT = HA + HFP + HSW + HBP;
   localparam int VT = VA + VFP + VSW + VBP;
   localparam int FRAME = HT * VT;
   localparam int MAXN = 8192;

   typedef struct {
      int unsigned en;
      int unsigned addr;
      int unsigned hs;
      int unsigned vs;
      int unsigned blank;
      int unsigned fs;
      int unsigned rgb;
   } exp_t;

   logic CLK;
   logic RESET_N;
   frame_reader_if bus ();

   frame_reader #(
      .H_ACTIVE(HA), .H_FP(HFP), .H_SYNC(HSW), .H_BP(HBP),
      .V_ACTIVE(VA), .V_FP(VFP), .V_SYNC(VSW), .V_BP(VBP),
      .RD_LAT(L)
   ) dut (
      .CLK(CLK),
      .RESET_N(RESET_N),
      .bus(bus)
   );

   initial CLK = 1'b0;
   always #5 CLK = ~CLK;

   function automatic logic [7:0] mem_val(input logic [18:0] a);
      logic [7:0] lo;
      lo = a[7:0];
      return (lo * 8'd13) ^ a[15:8] ^ 8'h3C;
   endfunction

   // Frame memory: the word addressed now appears on rd_data L cycles later.
   logic [18:0] ad [L];
   always @(posedge CLK) begin
      ad[0] <= bus.rd_addr;
      for (int k = 1; k < L; k++) ad[k] <= ad[k-1];
   end
   assign bus.rd_data = mem_val(ad[L-1]);

   int  n;
   bit  mute_h [MAXN];
   int  total;
   int  bad;
   exp_t expq [$];

   function automatic exp_t model(input int c);
      exp_t e;
      int p, hc, vc, q, qh, qv;
      bit act;
      p  = c % FRAME;
      hc = p % HT;
      vc = p / HT;
      e.en   = (hc < HA && vc < VA) ? 1 : 0;
      e.addr = vc * HA + hc;
      e.hs = 1; e.vs = 1; e.blank = 0; e.fs = 0; e.rgb = 0;
      if (c >= L + 1) begin
         q  = (c - L - 1) % FRAME;
         qh = q % HT;
         qv = q / HT;
         act = (qh < HA) && (qv < VA);
         e.hs    = (qh >= HA + HFP && qh < HA + HFP + HSW) ? 0 : 1;
         e.vs    = (qv >= VA + VFP && qv < VA + VFP + VSW) ? 0 : 1;
         e.blank = act ? 1 : 0;
         e.fs    = (q == 0) ? 1 : 0;
         if (act && !mute_h[c-1]) e.rgb = mem_val(19'(qv * HA + qh));
      end
      return e;
   endfunction

   // Reference model: advance the cycle index, track mute by its rules, queue the prediction.
   always @(posedge CLK) begin
      if (!RESET_N) begin
         n = 0;
         mute_h[0] = 1'b1;
      end else begin
         if (n + 1 < MAXN) begin
            if (bus.calculating) mute_h[n+1] = 1'b1;
            else if (n % FRAME == 0) mute_h[n+1] = 1'b0;
            else mute_h[n+1] = mute_h[n];
            n = n + 1;
         end
      end
      expq.push_back(model(n));
   end

   task automatic chk(input string nm, input int unsigned a, input int unsigned e);
      total++;
      if (a !== e) begin
         bad++;
         $display("FAIL %s cycle=%0d got=%0d want=%0d rst_n=%0b", nm, n, a, e, RESET_N);
      end
   endtask

   always @(negedge CLK) begin
      exp_t e;
      e = model(0);
      if (expq.size() == 0) begin
         if (RESET_N) chk("queue_nonempty", 0, 1);
      end else begin
         e = expq.pop_front();
      end
      if (!RESET_N) e = model(0);
      chk("rd_en", 32'(bus.rd_en), e.en);
      if (e.en != 0) chk("rd_addr", 32'(bus.rd_addr), e.addr);
      chk("hs", 32'(bus.hs), e.hs);
      chk("vs", 32'(bus.vs), e.vs);
      chk("blank_n", 32'(bus.blank_n), e.blank);
      chk("frame_start", 32'(bus.frame_start), e.fs);
      chk("red", 32'(bus.red), e.rgb);
      chk("green", 32'(bus.green), e.rgb);
      chk("blue", 32'(bus.blue), e.rgb);
   end

   function automatic bit calc_plan(input int c, input bit rnd);
      int fr, p, v;
      fr = c / FRAME;
      p  = c % FRAME;
      v  = p / HT;
      if (rnd) return ($urandom_range(0, 31) == 0);
      case (fr)
         2:       return (v >= 2 && v < 4);
         3:       return (v < 1);
         6:       return (p == 0);
         7, 8:    return ($urandom_range(0, 31) == 0);
         default: return 1'b0;
      endcase
   endfunction

   initial begin
      total = 0;
      bad = 0;
      n = 0;
      RESET_N = 1'b0;
      bus.calculating = 1'b0;
      repeat (3) @(posedge CLK);
      @(negedge CLK);
      #2 RESET_N = 1'b1;

      for (int k = 0; k < 9 * FRAME + 3; k++) begin
         @(negedge CLK);
         bus.calculating = calc_plan(n, 1'b0);
      end

      // Hit reset in the middle of an active line.
      for (int k = 0; k < HT && (n % HT) != 5; k++) @(posedge CLK);
      @(negedge CLK);
      bus.calculating = 1'b0;
      @(posedge CLK);
      #2 RESET_N = 1'b0;
      repeat (2) @(posedge CLK);
      @(negedge CLK);
      #2 RESET_N = 1'b1;

      for (int k = 0; k < 3 * FRAME; k++) begin
         @(negedge CLK);
         bus.calculating = (n / FRAME == 1) ? calc_plan(n, 1'b1) : 1'b0;
      end
      repeat (2) @(negedge CLK);
      #1;
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule

// File: doc/frame_reader.md
# frame_reader

Display-side reader for the fractal frame buffer. Generates 640x480@60 Hz VGA timing (800x525 totals), issues one read per active pixel to the 8-bit intensity frame memory that the fractal calculator fills, and drives grayscale RGB with syncs aligned to the returned data. It sits between the frame memory read port and the VGA DAC pins. It also mutes video while a calculation pass is rewriting the buffer.

## Interface

Parameters:
- H_ACTIVE, 640, visible pixels per line
- H_FP, 16, horizontal front porch (pixels)
- H_SYNC, 96, horizontal sync width (pixels)
- H_BP, 48, horizontal back porch (pixels)
- V_ACTIVE, 480, visible lines
- V_FP, 10, vertical front porch (lines)
- V_SYNC, 2, vertical sync width (lines)
- V_BP, 33, vertical back porch (lines)
- RD_LAT, 2, frame memory read latency in cycles (≥1)

Ports:
- CLK  in  1  pixel clock (25 MHz)
- RESET_N  in  1  asynchronous, active-low reset
- calculating  in  1  high while the calculator is writing the frame buffer
- rd_en  out  1  read strobe; high for active pixels only
- rd_addr  out  19  linear pixel address, y*H_ACTIVE + x
- rd_data  in  8  intensity; valid RD_LAT cycles after rd_en/rd_addr
- hs  out  1  horizontal sync, active low
- vs  out  1  vertical sync, active low
- blank_n  out  1  high during visible pixels
- red, green, blue  out  8 each  grayscale video
- frame_start  out  1  one-cycle pulse with output pixel (0,0)

## Operation

- Counters: hc counts 0..H_TOTAL-1 (799), then wraps to 0 and advances vc. vc counts 0..V_TOTAL-1 (524), then wraps to 0. Counters free-run after reset.
- active = (hc < H_ACTIVE) && (vc < V_ACTIVE). rd_en = active, combinational from the counters.
- Address: rd_addr comes from an incrementing counter, not a multiplier. It increments after each active cycle and reloads to 0 when hc=799 and vc=524, so it runs 0..307199 with no gaps.
- Sync, pre-delay: hs_i is low for hc in [H_ACTIVE+H_FP, H_ACTIVE+H_FP+H_SYNC-1] = [656,751]. vs_i is low for vc in [490,491]. fs_i = (hc==0 && vc==0).
- Alignment pipe: hs_i, vs_i, active and fs_i pass through a shift register of depth RD_LAT+1. rd_data is captured into the output register one cycle after it is valid.
- Video output:
  - red = green = blue = rd_data when the delayed active is 1 and mute is 0.
  - Otherwise all three are 0.
  - blank_n equals the delayed active, regardless of mute.
- Mute:
  - mute is a register set on any edge where calculating=1.
  - It clears only on the edge where fs_i=1 and calculating=0.
  - So a partially rewritten frame is never shown, and display resumes at the first full frame after calculating falls.
- Simultaneous events: if calculating=1 on the fs_i edge, set wins and mute stays 1.

## Timing

- Reset (RESET_N low, asynchronous):
  - hc = vc = 0, address counter = 0, mute = 1.
  - Pipe is loaded with inactive values: hs = 1, vs = 1, blank_n = 0, red/green/blue = 0, frame_start = 0.
  - rd_en follows the counters, so it is 1 at (0,0) during reset.
- Cycle 0 is the first rising edge with RESET_N high. Counters advance on that edge.
- Latency from counter state to outputs (hs, vs, blank_n, rgb, frame_start) is RD_LAT+1 cycles, 3 by default.
- frame_start is high for exactly one cycle per frame, coincident with the first visible pixel on the outputs.
- Periods: hs = 800 cycles, with 96 low. vs = 420000 cycles, with 1600 low.
- Reset mid-frame: all state returns to reset values immediately. Timing restarts at (0,0) with no partial-line artefacts beyond the blanked pipe.
- After reset, mute=1, so the first frame is black. The first frame shown is the one starting at the first fs_i edge with calculating=0.

## Test plan

1. Reset values: assert RESET_N=0 mid-line → hs=1, vs=1, blank_n=0, rgb=0, frame_start=0 within the same cycle. Release → first frame_start exactly 3 cycles after the first counter (0,0) state.
2. Sync timing over 2 frames: hs low for 96 consecutive cycles every 800. vs low for 1600 cycles every 420000. blank_n high for 640 cycles per line on 480 lines.
3. Addressing: rd_addr = 639 at (639,0) and 640 at (0,1). rd_addr = 307199 at (639,479), then 0 at the next active pixel. rd_en=0 for all 160 blank cycles of each line.
4. Data alignment: memory model returns rd_data = addr[7:0] after RD_LAT=2, calculating=0 → output red = 0x00,0x01,…,0x7F,… in lockstep with blank_n. Repeat with RD_LAT=1 and RD_LAT=4.
5. Mute:
   - Raise calculating at line 100 for 10 lines → rgb = 0 for the rest of that frame and the whole next frame if calculating is still high at its start.
   - Video resumes exactly at the frame_start following an fs_i edge with calculating=0.
   - Syncs and blank_n are unaffected throughout.
6. Boundary: calculating=1 only on the fs_i edge cycle → mute remains set for that entire frame.
